// File: rtl/sdpram_be.sv
// Simple dual-port RAM, one clock, with byte-lane write enables, per-lane
// even parity, selectable 1/2-cycle read latency, collision mode and an
// automatic zero-fill of the array after reset.
module sdpram_be #(
  parameter int Depth        = 16,
  parameter int Width        = 32,
  parameter int AddrWidth    = $clog2(Depth),
  parameter int ReadLatency  = 1,
  parameter int WriteFirst   = 1,
  parameter int ClearOnReset = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr_en,
  input  logic [Width/8-1:0]   i_wr_be,
  input  logic [AddrWidth-1:0] i_wr_addr,
  input  logic [Width-1:0]     i_wr_data,
  input  logic                 i_wr_perr_inj,
  input  logic                 i_rd_en,
  input  logic [AddrWidth-1:0] i_rd_addr,
  output logic [Width-1:0]     o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_rd_perr,
  output logic                 o_init_busy
);

  localparam int Lanes = Width / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t               state_reg, state_next;
  logic [AddrWidth-1:0] clr_cnt_reg, clr_cnt_next;

  logic                 clearing;
  logic                 wr_in_range, rd_in_range;
  logic                 wr_fire, rd_fire, collide;
  logic [AddrWidth-1:0] ram_waddr, rd_idx;

  logic                 v1_reg, oor1_reg;
  logic [Width-1:0]     data1, data1_masked;
  logic [Lanes-1:0]     mism1;
  logic                 perr1;

  // Init state register; reset restarts the clear from address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= (ClearOnReset != 0) ? CLEAR : READY;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // Clear sweeps one word per cycle, then hands over to normal traffic.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    if (state_reg == CLEAR) begin
      clr_cnt_next = clr_cnt_reg + 1'b1;
      if (clr_cnt_reg == AddrWidth'(Depth - 1)) begin
        state_next   = READY;
        clr_cnt_next = '0;
      end
    end
  end

  assign clearing    = (state_reg == CLEAR);
  assign o_init_busy = clearing;

  // Addresses beyond Depth exist only for non-power-of-two depths.
  assign wr_in_range = (32'(i_wr_addr) < Depth);
  assign rd_in_range = (32'(i_rd_addr) < Depth);
  assign wr_fire     = !clearing && i_wr_en && wr_in_range;
  assign rd_fire     = !clearing && i_rd_en;
  assign collide     = wr_fire && (i_wr_addr == i_rd_addr);
  assign ram_waddr   = clearing ? clr_cnt_reg : i_wr_addr;
  assign rd_idx      = rd_in_range ? i_rd_addr : '0;

  genvar gi;
  generate
    for (gi = 0; gi < Lanes; gi++) begin : g_lane
      logic [7:0] lane_mem [Depth];
      logic       lane_par [Depth];
      logic       lane_we;
      logic [7:0] new_byte;
      logic       new_par;
      logic [7:0] byte1_reg;
      logic       par1_reg;

      assign lane_we  = clearing || (wr_fire && i_wr_be[gi]);
      assign new_byte = clearing ? 8'h00 : i_wr_data[8*gi +: 8];
      assign new_par  = clearing ? 1'b0 : ((^i_wr_data[8*gi +: 8]) ^ i_wr_perr_inj);

      // Lane storage: data byte plus its parity bit, no reset on the array.
      always_ff @(posedge clk) begin
        if (lane_we) begin
          lane_mem[ram_waddr] <= new_byte;
          lane_par[ram_waddr] <= new_par;
        end
      end

      // Registered read; in write-first mode an enabled colliding lane
      // bypasses the array and returns the byte being written.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          byte1_reg <= 8'h00;
          par1_reg  <= 1'b0;
        end else if (rd_fire) begin
          if ((WriteFirst != 0) && collide && i_wr_be[gi]) begin
            byte1_reg <= new_byte;
            par1_reg  <= new_par;
          end else begin
            byte1_reg <= lane_mem[rd_idx];
            par1_reg  <= lane_par[rd_idx];
          end
        end
      end

      assign data1[8*gi +: 8] = byte1_reg;
      assign mism1[gi]        = par1_reg ^ (^byte1_reg);
    end
  endgenerate

  // First pipeline stage: valid pulse and out-of-range marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg   <= 1'b0;
      oor1_reg <= 1'b0;
    end else begin
      v1_reg <= rd_fire;
      if (rd_fire) begin
        oor1_reg <= !rd_in_range;
      end
    end
  end

  assign data1_masked = oor1_reg ? '0 : data1;
  assign perr1        = !oor1_reg && (|mism1);

  generate
    if (ReadLatency >= 2) begin : g_lat2
      logic             v2_reg;
      logic [Width-1:0] data2_reg;
      logic             perr2_reg;

      // Extra output stage; data holds between valid pulses.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v2_reg    <= 1'b0;
          data2_reg <= '0;
          perr2_reg <= 1'b0;
        end else begin
          v2_reg <= v1_reg;
          if (v1_reg) begin
            data2_reg <= data1_masked;
            perr2_reg <= perr1;
          end
        end
      end

      assign o_rd_valid = v2_reg;
      assign o_rd_data  = data2_reg;
      assign o_rd_perr  = v2_reg && perr2_reg;
    end else begin : g_lat1
      assign o_rd_valid = v1_reg;
      assign o_rd_data  = data1_masked;
      assign o_rd_perr  = v1_reg && perr1;
    end
  endgenerate

endmodule

// File: tb/tb_sdpram_be.sv
// Bench for sdpram_be: three instances (16/L1/write-first, 16/L2/read-first,
// 12/L2/write-first) share one stimulus stream; each has its own reference
// memory and expected-response queue, drained by a negedge monitor.
module tb_sdpram_be;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_be = 4'h0;
  logic [3:0]  wr_addr = 4'h0;
  logic [31:0] wr_data = 32'h0;
  logic        perr_inj = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = 4'h0;

  logic [31:0] rd_data  [3];
  logic        rd_valid [3];
  logic        rd_perr  [3];
  logic        busy     [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rel_cyc = 0;
  bit in_rst  = 1'b0;
  bit chk_en  = 1'b0;

  typedef struct {
    logic [31:0] d;
    logic        p;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // Reference memory: per instance, data word and lane parity bits.
  logic [31:0] mdat [3][16];
  logic [3:0]  mpar [3][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdpram_be #(.Depth(16), .Width(32), .AddrWidth(4), .ReadLatency(1),
              .WriteFirst(1), .ClearOnReset(1)) dut_a (
    .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_be(wr_be), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_perr_inj(perr_inj), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]), .o_rd_perr(rd_perr[0]),
    .o_init_busy(busy[0]));

  sdpram_be #(.Depth(16), .Width(32), .AddrWidth(4), .ReadLatency(2),
              .WriteFirst(0), .ClearOnReset(1)) dut_b (
    .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_be(wr_be), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_perr_inj(perr_inj), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]), .o_rd_perr(rd_perr[1]),
    .o_init_busy(busy[1]));

  sdpram_be #(.Depth(12), .Width(32), .AddrWidth(4), .ReadLatency(2),
              .WriteFirst(1), .ClearOnReset(1)) dut_c (
    .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_be(wr_be), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_perr_inj(perr_inj), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data[2]), .o_rd_valid(rd_valid[2]), .o_rd_perr(rd_perr[2]),
    .o_init_busy(busy[2]));

  function automatic int dep_of(input int k);
    return (k == 2) ? 12 : 16;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic bit wf_of(input int k);
    return (k != 1);
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void qpush(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t qpop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int qfront_cyc(input int k);
    case (k)
      0: return q0[0].cyc;
      1: return q1[0].cyc;
      default: return q2[0].cyc;
    endcase
  endfunction

  // One accepted cycle for instance k: the read sees the pre-write word,
  // except enabled lanes of a same-address write in write-first mode.
  function automatic void model_cycle(input int k, input bit we, input logic [3:0] be,
                                      input int wa, input logic [31:0] wd, input bit inj,
                                      input bit re, input int ra);
    exp_t        e;
    logic [31:0] d;
    logic [3:0]  p;
    logic        err;
    if (re) begin
      if (ra >= dep_of(k)) begin
        d = 32'h0;
        p = 4'h0;
      end else begin
        d = mdat[k][ra];
        p = mpar[k][ra];
        if (wf_of(k) && we && wa == ra) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
              d[8*b +: 8] = wd[8*b +: 8];
              p[b]        = (^wd[8*b +: 8]) ^ inj;
            end
          end
        end
      end
      err = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (p[b] != (^d[8*b +: 8])) err = 1'b1;
      end
      e.d   = d;
      e.p   = err;
      e.cyc = cyc + lat_of(k);
      qpush(k, e);
    end
    if (we && wa < dep_of(k)) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mdat[k][wa][8*b +: 8] = wd[8*b +: 8];
          mpar[k][wa][b]        = (^wd[8*b +: 8]) ^ inj;
        end
      end
    end
  endfunction

  task automatic step(input bit we, input logic [3:0] be, input int wa,
                      input logic [31:0] wd, input bit inj, input bit re, input int ra);
    wr_en    = we;
    wr_be    = be;
    wr_addr  = 4'(wa);
    wr_data  = wd;
    perr_inj = inj;
    rd_en    = re;
    rd_addr  = 4'(ra);
    for (int k = 0; k < 3; k++) begin
      if (!in_rst && (cyc - rel_cyc) >= dep_of(k))
        model_cycle(k, we, be, wa, wd, inj, re, ra);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 0, 32'h0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    in_rst = 1'b1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    repeat (n) @(posedge clk);
    #1;
    rst     = 1'b0;
    in_rst  = 1'b0;
    rel_cyc = cyc;
    // The clear sequence zeroes data and parity of every word.
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 16; a++) begin
        mdat[k][a] = 32'h0;
        mpar[k][a] = 4'h0;
      end
  endtask

  task automatic check_inst(input int k);
    exp_t e;
    bit   exp_busy;
    exp_busy = in_rst ? 1'b1 : ((cyc - rel_cyc) < dep_of(k));
    total++;
    if (busy[k] !== exp_busy) begin
      bad++;
      $display("FAIL init_busy inst%0d cyc=%0d: got %b want %b", k, cyc, busy[k], exp_busy);
    end
    while (qsize(k) > 0 && qfront_cyc(k) < cyc) begin
      e = qpop(k);
      total++;
      bad++;
      $display("FAIL missing_valid inst%0d: none at cyc=%0d, want data %h", k, e.cyc, e.d);
    end
    if (rd_valid[k] === 1'b1) begin
      total++;
      if (qsize(k) == 0) begin
        bad++;
        $display("FAIL unexpected_valid inst%0d cyc=%0d: got data %h, want no valid", k, cyc, rd_data[k]);
      end else begin
        e = qpop(k);
        if (rd_data[k] !== e.d || rd_perr[k] !== e.p || e.cyc != cyc) begin
          bad++;
          $display("FAIL read inst%0d cyc=%0d: got data %h perr %b, want data %h perr %b at cyc %0d",
                   k, cyc, rd_data[k], rd_perr[k], e.d, e.p, e.cyc);
        end
      end
    end else begin
      total++;
      if (rd_valid[k] !== 1'b0 || rd_perr[k] !== 1'b0) begin
        bad++;
        $display("FAIL idle_outputs inst%0d cyc=%0d: got valid %b perr %b, want 0 0",
                 k, cyc, rd_valid[k], rd_perr[k]);
      end
    end
  endtask

  // Monitor: compares every instance's outputs against its queue.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) check_inst(k);
    end
  end

  initial begin
    @(posedge clk);
    #1;
    rst    = 1'b1;
    in_rst = 1'b1;
    chk_en = 1'b1;
    do_reset(3);

    // Reads while clearing must be ignored.
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 0, 32'h0, 1'b0, 1'b1, i);
    idle(13);

    // Every word reads back zero after the clear.
    for (int a = 0; a < 16; a++) step(1'b0, 4'h0, 0, 32'h0, 1'b0, 1'b1, a);
    idle(3);

    // Byte-enable merge.
    step(1'b1, 4'hF, 3, 32'hAABBCCDD, 1'b0, 1'b0, 0);
    step(1'b1, 4'h5, 3, 32'h11223344, 1'b0, 1'b0, 0);
    step(1'b0, 4'h0, 0, 32'h0, 1'b0, 1'b1, 3);
    idle(3);

    // Back-to-back reads after filling 0..3.
    for (int a = 0; a < 4; a++) step(1'b1, 4'hF, a, 32'h10 + a, 1'b0, 1'b0, 0);
    for (int a = 0; a < 4; a++) step(1'b0, 4'h0, 0, 32'h0, 1'b0, 1'b1, a);
    idle(3);

    // Same-address collision.
    step(1'b1, 4'hF, 5, 32'h0000FFFF, 1'b0, 1'b0, 0);
    step(1'b1, 4'hC, 5, 32'h12345678, 1'b0, 1'b1, 5);
    step(1'b0, 4'h0, 0, 32'h0, 1'b0, 1'b1, 5);
    // Different-address read during a write.
    step(1'b1, 4'hF, 6, 32'hCAFEF00D, 1'b0, 1'b1, 3);
    idle(3);

    // Parity injection and repair.
    step(1'b1, 4'h2, 7, 32'hDEADBEEF, 1'b1, 1'b0, 0);
    step(1'b0, 4'h0, 0, 32'h0, 1'b0, 1'b1, 7);
    step(1'b1, 4'h2, 7, 32'hDEADBEEF, 1'b0, 1'b0, 0);
    step(1'b0, 4'h0, 0, 32'h0, 1'b0, 1'b1, 7);
    idle(3);

    // Randomized traffic over the full 4-bit address space.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom_range(0, 15),
           $urandom(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
           $urandom_range(0, 15));
    end
    idle(3);

    // Reset with a read in flight, then reset again partway through the clear.
    step(1'b0, 4'h0, 0, 32'h0, 1'b0, 1'b1, 3);
    do_reset(2);
    idle(5);
    do_reset(2);
    idle(16);

    // Out-of-range access on the 12-deep instance, then full readback.
    step(1'b1, 4'hF, 13, 32'h5A5A5A5A, 1'b0, 1'b0, 0);
    step(1'b0, 4'h0, 0, 32'h0, 1'b0, 1'b1, 13);
    step(1'b1, 4'hF, 2, 32'h01020304, 1'b0, 1'b0, 0);
    for (int a = 0; a < 16; a++) step(1'b0, 4'h0, 0, 32'h0, 1'b0, 1'b1, a);
    idle(5);

    for (int k = 0; k < 3; k++) begin
      total++;
      if (qsize(k) != 0) begin
        bad++;
        $display("FAIL drain inst%0d: got %0d pending reads, want 0", k, qsize(k));
      end
    end
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdpram_be.md
Name: sdpram_be

Overview:
- Single-clock simple dual-port RAM: one write port, one read port.
- Successor to the team's dual-port RAM, generalised with:
  - per-byte write enables
  - selectable read latency
  - read/write collision mode
  - per-byte parity checking
  - automatic memory clear after reset
- Storage element behind FIFOs, descriptor tables and packet buffers wherever both ports share one clock.

Parameters:
- Depth, 16, number of words (any value >= 2; non-power-of-two allowed).
- Width, 32, data bits per word; must be a multiple of 8.
- AddrWidth, $clog2(Depth), address port width.
- ReadLatency, 1, cycles from accepted read to o_rd_valid; legal values 1 or 2.
- WriteFirst, 1, 1 = same-address read returns new data; 0 = returns old data.
- ClearOnReset, 1, 1 = zero every word after reset before accepting traffic.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_wr_en  input  1  write request.
- i_wr_be  input  Width/8  byte-lane enables; bit b covers data[8b+7:8b].
- i_wr_addr  input  AddrWidth  write address.
- i_wr_data  input  Width  write data.
- i_wr_perr_inj  input  1  test hook; inverts stored parity of every lane written this cycle.
- i_rd_en  input  1  read request.
- i_rd_addr  input  AddrWidth  read address.
- o_rd_data  output  Width  read data.
- o_rd_valid  output  1  one-cycle pulse; o_rd_data and o_rd_perr valid.
- o_rd_perr  output  1  parity mismatch on one or more lanes of the returned word.
- o_init_busy  output  1  clear sequence in progress; all requests ignored.

Behaviour:
- Reset values: o_rd_data = 0, o_rd_valid = 0, o_rd_perr = 0. o_init_busy = 1 if ClearOnReset, else 0.
  - Read pipeline registers cleared.
  - RAM contents not reset directly.
- Storage: per word, Width data bits plus Width/8 parity bits. Lane parity = XOR of the lane's 8 bits (even parity).
- Init FSM, states CLEAR and READY:
  - Reset enters CLEAR if ClearOnReset, else READY.
  - CLEAR writes data 0 with parity 0 to address counter 0..Depth-1, one word per cycle.
  - After writing Depth-1, the FSM moves to READY and o_init_busy drops on the following edge. Total clear = Depth cycles after rst deasserts.
  - rst asserted mid-clear: counter returns to 0 and the clear restarts from address 0.
  - While in CLEAR, i_wr_en and i_rd_en are ignored: no write, no o_rd_valid.
- Write, in READY with i_wr_en = 1:
  - Each lane with its be bit set stores its data byte and parity ^byte ^ i_wr_perr_inj.
  - Lanes with be = 0 keep data and parity unchanged.
  - be = 0 with i_wr_en = 1 is a legal no-op.
- Read, in READY with i_rd_en = 1:
  - ReadLatency = 1: o_rd_valid pulses on the next edge, with o_rd_data and o_rd_perr.
  - ReadLatency = 2: one extra register stage; valid two edges after the request.
  - Back-to-back reads give one valid per cycle, in order.
  - o_rd_data holds its last value when o_rd_valid = 0.
  - o_rd_perr = OR over lanes of (stored parity != recomputed parity); it is 0 whenever o_rd_valid = 0.
- Collision (read and write to the same address in the same cycle):
  - WriteFirst = 1: enabled lanes return the new byte and parity; disabled lanes return stored content.
  - WriteFirst = 0: all lanes return the pre-write content.
  - Reads at different addresses are unaffected by a concurrent write.
- Out-of-range address (>= Depth; possible only for non-power-of-two Depth):
  - Write is dropped.
  - Read still produces o_rd_valid, with o_rd_data = 0 and o_rd_perr = 0.
- Reset mid-operation: any in-flight read is discarded; no o_rd_valid appears after rst deasserts unless a new read is issued.

Test Plan:
- Clear sequence: Depth=16, ClearOnReset=1; release rst.
  - Required: o_init_busy = 1 for exactly 16 cycles.
  - Required: reads of addresses 0..15 return 0 with o_rd_perr = 0.
  - Required: a read issued while busy produces no o_rd_valid.
- Byte-enable merge: write 0xAABBCCDD to addr 3 with be=1111, then 0x11223344 with be=0101; read addr 3.
  - Required: o_rd_data = 0xAA22CC44, o_rd_perr = 0.
- Latency and throughput: ReadLatency=2; write addrs 0..3 with 0x10..0x13; read 0..3 back to back.
  - Required: o_rd_valid high exactly 4 consecutive cycles starting 2 cycles after the first read; data 0x10..0x13 in order.
- Collision modes: addr 5 holds 0x0000FFFF; same cycle, write 0x12345678 with be=1100 and read addr 5.
  - WriteFirst=1: returns 0x1234FFFF.
  - WriteFirst=0: returns 0x0000FFFF.
- Parity injection: write 0xDEADBEEF to addr 7 with be=0010 and i_wr_perr_inj=1; read addr 7.
  - Required: o_rd_perr = 1 with o_rd_valid.
  - Rewrite lane 1 without injection, then read: o_rd_perr = 0.
- Reset mid-clear and out-of-range: Depth=12.
  - Assert rst at clear cycle 5, release. Required: o_init_busy high for 12 full cycles again.
  - Then write addr 13 and read addr 13. Required: o_rd_valid = 1, o_rd_data = 0, o_rd_perr = 0; reads of addrs 0..11 unchanged.
